// File: rtl/forward_select_unit.sv
// Purpose: operand forwarding select generator and load-use hazard detector
//          for the EX-stage rs1/rs2 operand muxes of a 4-stage RISC-V pipeline.
// Latency: codes computed in ID are registered and drive SELECT1/2 one cycle
//          later (the instruction's EX cycle); STALL is combinational.
// Backpressure: BUSYWAIT freezes all tracking and the select registers; STALL
//          requests a one-cycle hold of PC/IF/ID and a bubble into EX.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   BUSYWAIT, FLUSH       pipeline freeze, redirect (kills ID instruction)
//   ID_RS1/2, ID_RS1/2_USE  ID-stage source operands and their use flags
//   ID_RD, ID_REG_WRITE, ID_MEM_READ  ID-stage destination info
//   SELECT1/2             mux selects: 0 regfile, 1 EX/MEM alu, 2 MEM/WB alu,
//                         3 MEM/WB load data, 4 retired-write holding register
//   STALL                 load-use stall request
module forward_select_unit #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUSYWAIT,
  input  logic                  FLUSH,
  input  logic [ADDR_WIDTH-1:0] ID_RS1,
  input  logic [ADDR_WIDTH-1:0] ID_RS2,
  input  logic                  ID_RS1_USE,
  input  logic                  ID_RS2_USE,
  input  logic [ADDR_WIDTH-1:0] ID_RD,
  input  logic                  ID_REG_WRITE,
  input  logic                  ID_MEM_READ,
  output logic [2:0]            SELECT1,
  output logic [2:0]            SELECT2,
  output logic                  STALL
);

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } entry_t;

  localparam logic [2:0] SEL_REGFILE = 3'd0;
  localparam logic [2:0] SEL_EXMEM   = 3'd1;
  localparam logic [2:0] SEL_MEMWB   = 3'd2;
  localparam logic [2:0] SEL_LOAD    = 3'd3;
  localparam logic [2:0] SEL_RETIRED = 3'd4;

  // Once an instruction leaves WB its result sits in the holding register
  // and then in the register file. A consumer in ID that sees the writer in
  // the WB entry will meet it in the holding register during its EX cycle;
  // anything older is already readable from the register file, so no entry
  // beyond WB is needed to pick a select code.
  entry_t ex_q, ex_d;
  entry_t mem_q, mem_d;
  entry_t wb_q, wb_d;

  logic [2:0] select1_q, select1_d;
  logic [2:0] select2_q, select2_d;
  logic [2:0] code1, code2;
  logic       load_hazard;
  logic       stall;

  // An entry is a forwarding source only if it really writes a non-x0 register.
  function automatic logic src_hit(entry_t e, logic [ADDR_WIDTH-1:0] rs);
    return e.vld && e.reg_write && (e.rd != '0) && (e.rd == rs);
  endfunction

  // Youngest producer wins. A load still in EX is not forwardable; that case
  // is caught by the stall logic, which zeroes the registered code anyway.
  function automatic logic [2:0] fwd_code(logic use_rs, logic [ADDR_WIDTH-1:0] rs,
                                          entry_t ex_e, entry_t mem_e, entry_t wb_e);
    logic [2:0] code;
    code = SEL_REGFILE;
    if (use_rs && (rs != '0)) begin
      if (src_hit(ex_e, rs) && !ex_e.mem_read) begin
        code = SEL_EXMEM;
      end else if (src_hit(mem_e, rs)) begin
        code = mem_e.mem_read ? SEL_LOAD : SEL_MEMWB;
      end else if (src_hit(wb_e, rs)) begin
        code = SEL_RETIRED;
      end
    end
    return code;
  endfunction

  always_comb begin
    code1 = fwd_code(ID_RS1_USE, ID_RS1, ex_q, mem_q, wb_q);
    code2 = fwd_code(ID_RS2_USE, ID_RS2, ex_q, mem_q, wb_q);

    load_hazard = ex_q.vld && ex_q.reg_write && ex_q.mem_read && (ex_q.rd != '0) &&
                  ((ID_RS1_USE && (ID_RS1 == ex_q.rd)) ||
                   (ID_RS2_USE && (ID_RS2 == ex_q.rd)));
    // A redirect kills the dependent instruction, so there is nothing to stall.
    stall = load_hazard && !FLUSH && !RESET;
  end

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    select1_d = select1_q;
    select2_d = select2_q;

    if (!BUSYWAIT) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (stall || FLUSH) begin
        ex_d      = '0;
        select1_d = SEL_REGFILE;
        select2_d = SEL_REGFILE;
      end else begin
        ex_d.vld       = 1'b1;
        ex_d.rd        = ID_RD;
        ex_d.reg_write = ID_REG_WRITE;
        ex_d.mem_read  = ID_MEM_READ;
        select1_d      = code1;
        select2_d      = code2;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      select1_q <= SEL_REGFILE;
      select2_q <= SEL_REGFILE;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      select1_q <= select1_d;
      select2_q <= select2_d;
    end
  end

  assign SELECT1 = select1_q;
  assign SELECT2 = select2_q;
  assign STALL   = stall;

endmodule

// File: tb/tb_forward_select_unit.sv
module tb_forward_select_unit;

  logic       CLK = 1'b0;
  logic       RESET, BUSYWAIT, FLUSH;
  logic [4:0] ID_RS1, ID_RS2, ID_RD;
  logic       ID_RS1_USE, ID_RS2_USE, ID_REG_WRITE, ID_MEM_READ;
  logic [2:0] SELECT1, SELECT2;
  logic       STALL;

  forward_select_unit #(.ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .FLUSH(FLUSH),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RS1_USE(ID_RS1_USE), .ID_RS2_USE(ID_RS2_USE),
    .ID_RD(ID_RD), .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ),
    .SELECT1(SELECT1), .SELECT2(SELECT2), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  // One ID-stage cycle: inputs, the expected combinational STALL during the
  // cycle, and the expected SELECT1/SELECT2 after the following posedge.
  typedef struct {
    string      name;
    logic       rst, bw, fl;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, mr;
    logic       st;
    logic [2:0] s1, s2;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] s1, s2;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(string name, logic rst, logic bw, logic fl,
                              logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic rw, logic mr,
                              logic st, logic [2:0] s1, logic [2:0] s2);
    vec_t v;
    v.name = name; v.rst = rst; v.bw = bw; v.fl = fl;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.mr = mr; v.st = st; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step(vec_t v);
    exp_t e;
    @(negedge CLK);
    RESET = v.rst; BUSYWAIT = v.bw; FLUSH = v.fl;
    ID_RS1 = v.rs1; ID_RS1_USE = v.u1; ID_RS2 = v.rs2; ID_RS2_USE = v.u2;
    ID_RD = v.rd; ID_REG_WRITE = v.rw; ID_MEM_READ = v.mr;
    #1;
    chk({v.name, " stall"}, int'(STALL), int'(v.st));
    e.name = v.name; e.s1 = v.s1; e.s2 = v.s2;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk({v.name, " scoreboard empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.name, " select1"}, int'(SELECT1), int'(e.s1));
      chk({e.name, " select2"}, int'(SELECT2), int'(e.s2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name        rst bw fl  rs1 u1 rs2 u2  rd rw mr  st s1 s2
    vecs.push_back(mk("t1_add",     0,0,0,  1,1, 2,1,  5,1,0,  0,0,0));
    vecs.push_back(mk("t1_sub",     0,0,0,  5,1, 6,1, 10,1,0,  0,1,0));
    vecs.push_back(mk("t1_nop",     0,0,0,  0,0, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t2_w1",      0,0,0,  0,0, 0,0,  7,1,0,  0,0,0));
    vecs.push_back(mk("t2_w2",      0,0,0,  0,0, 0,0,  7,1,0,  0,0,0));
    vecs.push_back(mk("t2_w3",      0,0,0,  0,0, 0,0,  7,1,0,  0,0,0));
    vecs.push_back(mk("t2_d123",    0,0,0,  7,1, 0,0,  0,0,0,  0,1,0));
    vecs.push_back(mk("t2_w4",      0,0,0,  0,0, 0,0,  7,1,0,  0,0,0));
    vecs.push_back(mk("t2_w5",      0,0,0,  0,0, 0,0,  7,1,0,  0,0,0));
    vecs.push_back(mk("t2_gap",     0,0,0,  0,0, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t2_d23",     0,0,0,  7,1, 0,0,  0,0,0,  0,2,0));
    vecs.push_back(mk("t2_w6",      0,0,0,  0,0, 0,0,  7,1,0,  0,0,0));
    vecs.push_back(mk("t2_gap2",    0,0,0,  0,0, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t2_gap3",    0,0,0,  0,0, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t2_d3",      0,0,0,  7,1, 0,0,  0,0,0,  0,4,0));
    vecs.push_back(mk("t2_d4",      0,0,0,  7,1, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t3_lw",      0,0,0,  2,1, 0,0,  8,1,1,  0,0,0));
    vecs.push_back(mk("t3_stall",   0,0,0,  3,1, 8,1, 11,1,0,  1,0,0));
    vecs.push_back(mk("t3_resume",  0,0,0,  3,1, 8,1, 11,1,0,  0,0,3));
    vecs.push_back(mk("t3_nop",     0,0,0,  0,0, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t3_w12",     0,0,0,  0,0, 0,0, 12,1,0,  0,0,0));
    vecs.push_back(mk("t3_same",    0,0,0, 12,1,12,1,  0,0,0,  0,1,1));
    vecs.push_back(mk("t4_w0",      0,0,0,  0,0, 0,0,  0,1,0,  0,0,0));
    vecs.push_back(mk("t4_r0",      0,0,0,  0,1, 0,1,  0,0,0,  0,0,0));
    vecs.push_back(mk("t4_w13",     0,0,0,  0,0, 0,0, 13,1,0,  0,0,0));
    vecs.push_back(mk("t4_nouse",   0,0,0, 13,1,13,0,  0,0,0,  0,1,0));
    vecs.push_back(mk("t4_lw0",     0,0,0,  0,0, 0,0,  0,1,1,  0,0,0));
    vecs.push_back(mk("t4_rlw0",    0,0,0,  0,1, 0,1,  0,0,0,  0,0,0));
    vecs.push_back(mk("t5_lw9",     0,0,0,  0,0, 0,0,  9,1,1,  0,0,0));
    vecs.push_back(mk("t5_flush",   0,0,1,  9,1, 0,0, 14,1,0,  0,0,0));
    vecs.push_back(mk("t5_after",   0,0,0,  0,0, 9,1,  0,0,0,  0,0,3));
    vecs.push_back(mk("t5_killed",  0,0,0, 14,1, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t5_w15",     0,0,0,  0,0, 0,0, 15,1,0,  0,0,0));
    vecs.push_back(mk("t5_w16",     0,0,0, 15,1, 0,0, 16,1,0,  0,1,0));
    vecs.push_back(mk("t5_busy1",   0,1,0, 16,1,15,1,  0,0,0,  0,1,0));
    vecs.push_back(mk("t5_busy2",   0,1,0, 16,1,15,1,  0,0,0,  0,1,0));
    vecs.push_back(mk("t5_busy3",   0,1,0, 16,1,15,1,  0,0,0,  0,1,0));
    vecs.push_back(mk("t5_release", 0,0,0, 16,1,15,1,  0,0,0,  0,1,2));
    vecs.push_back(mk("t5_nop",     0,0,0,  0,0, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t5_lw20",    0,0,0,  0,0, 0,0, 20,1,1,  0,0,0));
    vecs.push_back(mk("t5_bwstall", 0,1,0, 20,1, 0,0,  0,0,0,  1,0,0));
    vecs.push_back(mk("t5_stall2",  0,0,0, 20,1, 0,0,  0,0,0,  1,0,0));
    vecs.push_back(mk("t5_load3",   0,0,0, 20,1, 0,0,  0,0,0,  0,3,0));
    vecs.push_back(mk("t6_w3a",     0,0,0,  0,0, 0,0,  3,1,0,  0,0,0));
    vecs.push_back(mk("t6_w3b",     0,0,0,  0,0, 0,0,  3,1,0,  0,0,0));
    vecs.push_back(mk("t6_rst",     1,0,0,  3,1, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t6_r3",      0,0,0,  3,1, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t6_lw3",     0,0,0,  0,0, 0,0,  3,1,1,  0,0,0));
    vecs.push_back(mk("t6_rsthaz",  1,0,0,  3,1, 0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk("t6_r3b",     0,0,0,  3,1, 0,0,  0,0,0,  0,0,0));

    // Reset state, hand-driven before the table.
    RESET = 1'b1; BUSYWAIT = 1'b0; FLUSH = 1'b0;
    ID_RS1 = '0; ID_RS2 = '0; ID_RD = '0;
    ID_RS1_USE = 1'b0; ID_RS2_USE = 1'b0; ID_REG_WRITE = 1'b0; ID_MEM_READ = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset select1", int'(SELECT1), 0);
    chk("reset select2", int'(SELECT2), 0);
    chk("reset stall",   int'(STALL),   0);

    // Hazard present while RESET is high must not request a stall.
    ID_RS1 = 5'd8; ID_RS1_USE = 1'b1;
    #1;
    chk("reset stall with inputs", int'(STALL), 0);

    foreach (vecs[i]) step(vecs[i]);

    chk("scoreboard drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/forward_select_unit.md
Name: forward_select_unit

Overview:
- Generates the 3-bit SELECT codes that drive the two EX-stage operand mux_5x1_32bit instances (rs1 path and rs2 path) of the 4-stage ID/EX/MEM/WB RISC-V pipeline.
- Tracks the destination register of every in-flight and just-retired instruction in an internal shift pipeline.
- Compares each ID-stage operand against that pipeline, registers the resulting forwarding code into EX, and raises a load-use STALL when forwarding cannot cover the hazard.

Parameters:
ADDR_WIDTH, 5, register address width (x0..x31)

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
BUSYWAIT  input  1  memory busy; whole pipeline frozen this cycle
FLUSH  input  1  branch/jump redirect; kills the instruction currently in ID
ID_RS1  input  ADDR_WIDTH  rs1 address of the ID-stage instruction
ID_RS2  input  ADDR_WIDTH  rs2 address of the ID-stage instruction
ID_RS1_USE  input  1  ID instruction reads rs1
ID_RS2_USE  input  1  ID instruction reads rs2
ID_RD  input  ADDR_WIDTH  rd address of the ID-stage instruction
ID_REG_WRITE  input  1  ID instruction writes rd
ID_MEM_READ  input  1  ID instruction is a load
SELECT1  output  3  rs1 operand mux select, valid while the instruction is in EX
SELECT2  output  3  rs2 operand mux select, valid while the instruction is in EX
STALL  output  1  combinational load-use stall request: hold PC/IF/ID, bubble EX

Behaviour:
- Reset is synchronous and active-high on CLK. There is a single clock domain.
- Select encoding, matching the mux inputs:
  - 0 = register file value
  - 1 = EX/MEM ALU result
  - 2 = MEM/WB ALU result
  - 3 = MEM/WB load data
  - 4 = retired-write holding register (covers the regfile write-at-end-of-WB vs combinational ID read)
- Tracking entries: EX, MEM, WB, RET. Each entry holds {valid, rd, reg_write, mem_read}. An entry qualifies as a match source only when valid & reg_write & rd != 0.
- Shift each posedge when BUSYWAIT=0: RET<=WB, WB<=MEM, MEM<=EX.
  - EX<=ID fields with valid=1, except EX<=bubble (valid=0) when STALL or FLUSH.
- BUSYWAIT=1: all entries and SELECT1/SELECT2 hold, regardless of STALL/FLUSH. RESET still takes effect.
- Per-operand code, computed at ID time (only if RSx_USE=1 and RSx != 0, else 0). Priority is youngest first:
  - match EX entry (non-load) -> 1
  - else match MEM entry -> 3 if mem_read, else 2
  - else match WB entry -> 4
  - else 0
- STALL = EX entry valid & mem_read & reg_write & rd != 0 & (rs1 hit or rs2 hit with its USE bit set). Forced to 0 when FLUSH=1 or RESET=1.
- SELECT register update, when BUSYWAIT=0: load the computed codes. Load 0 instead when STALL or FLUSH (the bubble entering EX).
- Latency: a code computed in cycle t appears on SELECTx in cycle t+1, aligned with the instruction's EX cycle.
- Stall duration: a load-use stall lasts exactly one cycle. The next cycle, the load has moved to MEM and the held instruction gets code 3.
- Simultaneous events:
  - FLUSH with a hazard -> no STALL, bubble inserted.
  - RESET dominates everything.
- Reset values: all entries invalid, SELECT1=SELECT2=0, STALL=0. Reset mid-operation discards all in-flight tracking; the next cycle behaves as an empty pipeline.
- x0 is never forwarded, even when an entry wrote rd=0.
- rs1 and rs2 are evaluated independently. rs1==rs2 yields identical codes.

Test Plan:
1. EX-to-EX forward: the cycle after reset, issue ADD x5 (rd=5, RW=1), then SUB reading rs1=5, rs2=6 -> cycle after SUB in ID: SELECT1=1, SELECT2=0, STALL=0 throughout.
2. Priority and distance: writes to x7 at distances 1, 2 and 3 ahead of a consumer of x7 -> SELECT1=1. Then, with only the distance-2 and distance-3 writers, SELECT1=2. With only the distance-3 writer, SELECT1=4.
3. Load-use: LW x8 followed immediately by ADD rs2=8:
   - STALL=1 for exactly one cycle; the EX-bound SELECTs are 0 (bubble).
   - Next cycle STALL=0; SELECT2=3 when ADD enters EX.
4. x0 and unused operands:
   - writer with rd=0 followed by a reader of rs1=0 -> SELECT1=0.
   - RS2_USE=0 with a matching rs2 -> SELECT2=0.
   - LW x0 then reader of x0 -> no STALL.
5. FLUSH and BUSYWAIT:
   - LW x9 in EX with FLUSH=1 and a dependent ID instruction -> STALL=0; the next SELECTs are 0.
   - BUSYWAIT=1 for 3 cycles mid-sequence -> SELECT1/SELECT2 and tracking frozen; forwarding resumes with correct codes after release.
6. Reset mid-stream: RESET pulse with writers to x3 in flight, then a reader of x3 -> SELECT1=0, STALL=0.
